calc_engine: RTL and testbench

Arithmetic engine sitting directly downstream of the AHB slave register interface. It consumes the enable strobe, opcode and two 16-bit operands programmed over AHB, and executes one operation per rising edge of enable. It returns a 32-bit result plus busy/done/error status, which the register interface exposes at RES_ADDR (0x10). Add/sub complete in one cycle; multiply/divide are iterative, 16 cycles.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/calc_muldiv_iter.sv | 87 ++++++++
 rtl/calc_engine.sv | 138 +++++++++++++
 tb/tb_calc_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_engine arithmetic block.
// The iteration count and divide-by-zero quotient assume the default 16-bit operand width.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int                CNT_W     = 4;
    localparam logic [CNT_W-1:0]  ITER_LAST = 4'd15;
    localparam logic [15:0]       DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/calc_muldiv_iter.sv
// Shared 32-bit accumulator for shift-add multiply and restoring divide, one step per cycle.
// The divider step exists only when CALC_DIV_EN is defined.
module calc_muldiv_iter
    import calc_pkg::*;
#(
    parameter int OPW = 16
) (
    input  logic             hclk_i,
    input  logic             hresetn_i,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [OPW-1:0]   operand_a,
    input  logic [OPW-1:0]   operand_b,
    input  logic             step,
    output logic             last,
    output logic [2*OPW-1:0] value
);

    logic [2*OPW-1:0] acc;
    logic [OPW-1:0]   operand_q;
    logic [CNT_W-1:0] count;
    logic [OPW:0]     mul_sum;
    logic [2*OPW-1:0] mul_next;
`ifdef CALC_DIV_EN
    logic             is_div;
    logic [OPW:0]     div_shift;
    logic [OPW:0]     div_trial;
    logic [2*OPW-1:0] div_next;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    always_comb begin
        mul_sum  = {1'b0, acc[2*OPW-1:OPW]} + (acc[0] ? {1'b0, operand_q} : '0);
        mul_next = {mul_sum, acc[OPW-1:1]};
    end

`ifdef CALC_DIV_EN
    // Divide: acc = {remainder, dividend/quotient}, shifted left each step
    always_comb begin
        div_shift = {acc[2*OPW-1:OPW], acc[OPW-1]};
        div_trial = div_shift - {1'b0, operand_q};
        if (!div_trial[OPW]) begin
            div_next = {div_trial[OPW-1:0], acc[OPW-2:0], 1'b1};
        end else begin
            div_next = {div_shift[OPW-1:0], acc[OPW-2:0], 1'b0};
        end
    end

    assign value = is_div ? div_next : mul_next;
`else
    assign value = mul_next;
`endif

    assign last = (count == ITER_LAST);

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            acc       <= '0;
            operand_q <= '0;
            count     <= '0;
`ifdef CALC_DIV_EN
            is_div    <= 1'b0;
`endif
        end else if (start) begin
            count <= '0;
`ifdef CALC_DIV_EN
            is_div <= (opcode == OP_DIV);
`endif
            if (opcode == OP_DIV) begin
`ifdef CALC_DIV_EN
                acc       <= {{OPW{1'b0}}, operand_a};
                operand_q <= operand_b;
`else
                acc       <= '0;
                operand_q <= '0;
`endif
            end else begin
                acc       <= {{OPW{1'b0}}, operand_b};
                operand_q <= operand_a;
            end
        end else if (step) begin
            acc   <= value;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/calc_engine.sv
// Arithmetic engine behind the AHB register interface: ADD/SUB in one cycle, MUL/DIV in 16.
// Define CALC_DIV_EN to build the divider; otherwise DIV completes at once with an error.
module calc_engine
    import calc_pkg::*;
#(
    parameter int OPW = 16
) (
    input  logic             hclk_i,
    input  logic             hresetn_i,
    input  logic             enable_i,
    input  logic [1:0]       opcode_i,
    input  logic [OPW-1:0]   operate_a_i,
    input  logic [OPW-1:0]   operate_b_i,
    output logic [2*OPW-1:0] result_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    state_e           state;
    state_e           state_next;
    logic             enable_d;
    logic             start;
    opcode_e          op_q;
    logic [OPW-1:0]   a_q;
    logic [OPW-1:0]   b_q;
    logic             iter_last;
    logic [2*OPW-1:0] iter_value;
    logic             load_result;
    logic [2*OPW-1:0] result_next;
    logic             err_next;
    logic [OPW:0]     add_sum;

    assign start  = enable_i & ~enable_d & (state == IDLE);
    assign busy_o = (state == EXEC);
    assign done_o = (state == DONE);

    calc_muldiv_iter #(
        .OPW (OPW)
    ) u_muldiv (
        .hclk_i    (hclk_i),
        .hresetn_i (hresetn_i),
        .start     (start),
        .opcode    (opcode_i),
        .operand_a (operate_a_i),
        .operand_b (operate_b_i),
        .step      (busy_o),
        .last      (iter_last),
        .value     (iter_value)
    );

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The result is loaded exactly when EXEC hands over to DONE
    always_comb begin
        state_next  = state;
        load_result = 1'b0;
        result_next = '0;
        err_next    = 1'b0;
        add_sum     = {1'b0, a_q} + {1'b0, b_q};
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        load_result = 1'b1;
                        result_next = {{(OPW-1){1'b0}}, add_sum};
                    end
                    OP_SUB: begin
                        load_result = 1'b1;
                        result_next = {{OPW{1'b0}}, a_q} - {{OPW{1'b0}}, b_q};
                    end
                    OP_MUL: begin
                        load_result = iter_last;
                        result_next = iter_value;
                    end
                    OP_DIV: begin
`ifdef CALC_DIV_EN
                        if (b_q == '0) begin
                            load_result = 1'b1;
                            result_next = {a_q, DIV0_QUOT};
                            err_next    = 1'b1;
                        end else begin
                            load_result = iter_last;
                            result_next = iter_value;
                        end
`else
                        load_result = 1'b1;
                        result_next = '0;
                        err_next    = 1'b1;
`endif
                    end
                    default: ;
                endcase
                if (load_result) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured only on an accepted start, so changes while busy are ignored
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            enable_d <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_o <= '0;
            err_o    <= 1'b0;
        end else begin
            enable_d <= enable_i;
            if (start) begin
                op_q  <= opcode_e'(opcode_i);
                a_q   <= operate_a_i;
                b_q   <= operate_b_i;
                err_o <= 1'b0;
            end
            if (load_result) begin
                result_o <= result_next;
                err_o    <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_calc_engine;

    localparam logic [1:0] T_ADD = 2'b00;
    localparam logic [1:0] T_SUB = 2'b01;
    localparam logic [1:0] T_MUL = 2'b10;
    localparam logic [1:0] T_DIV = 2'b11;

    logic        hclk_i = 1'b0;
    logic        hresetn_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [1:0]  opcode_i = 2'b00;
    logic [15:0] operate_a_i = '0;
    logic [15:0] operate_b_i = '0;
    logic [31:0] result_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    calc_engine dut (
        .hclk_i      (hclk_i),
        .hresetn_i   (hresetn_i),
        .enable_i    (enable_i),
        .opcode_i    (opcode_i),
        .operate_a_i (operate_a_i),
        .operate_b_i (operate_b_i),
        .result_o    (result_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 hclk_i = ~hclk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Reference model: results straight from arithmetic definitions
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wa;
        logic [31:0] wb;
        logic [31:0] r;
        wa = {16'h0, a};
        wb = {16'h0, b};
        case (op)
            T_ADD: r = wa + wb;
            T_SUB: r = wa - wb;
            T_MUL: r = wa * wb;
            default: begin
`ifdef CALC_DIV_EN
                if (b == 16'h0) r = {a, 16'hFFFF};
                else            r = {16'(wa % wb), 16'(wa / wb)};
`else
                r = 32'h0;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic logic ref_err(input logic [1:0] op, input logic [15:0] b);
`ifdef CALC_DIV_EN
        return (op == T_DIV) && (b == 16'h0);
`else
        return (op == T_DIV) && (b == b);
`endif
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [15:0] b);
        if (op == T_ADD || op == T_SUB) return 1;
        if (op == T_MUL) return 16;
`ifdef CALC_DIV_EN
        return (b == 16'h0) ? 1 : 16;
`else
        return (b == b) ? 1 : 1;
`endif
    endfunction

    task automatic tick();
        @(posedge hclk_i);
        #1;
    endtask

    // Drives one operation and observes it; comparisons are made by the calling test
    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int done_cyc, output logic [31:0] res, output logic res_err,
                         output logic status_ok, output logic start_ok);
        int c;
        enable_i = 1'b0;
        tick();
        opcode_i = op;
        operate_a_i = a;
        operate_b_i = b;
        enable_i = 1'b1;
        tick();
        start_ok = (busy_o === 1'b1) && (done_o === 1'b0) && (err_o === 1'b0);
        done_cyc = -1;
        res = '0;
        res_err = 1'b0;
        status_ok = 1'b1;
        c = 0;
        while (done_cyc < 0 && c < 40) begin
            tick();
            c++;
            if (done_o === 1'b1) begin
                done_cyc = c;
                res = result_o;
                res_err = err_o;
                if (busy_o !== 1'b0) status_ok = 1'b0;
            end else if (busy_o !== 1'b1) begin
                status_ok = 1'b0;
            end
        end
        tick();
        if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== res) status_ok = 1'b0;
        enable_i = 1'b0;
    endtask

    task automatic test_reset();
        hresetn_i = 1'b0;
        enable_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({result_o, busy_o, done_o, err_o} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL reset_state got %h exp 0", {result_o, busy_o, done_o, err_o});
        end
        hresetn_i = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [1:0]  ops [8] = '{T_ADD, T_SUB, T_MUL, T_DIV, T_DIV, T_ADD, T_SUB, T_MUL};
        logic [15:0] as  [8] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'd100, 16'h1234, 16'h0000, 16'hFFFF, 16'h0000};
        logic [15:0] bs  [8] = '{16'h0001, 16'h0002, 16'hFFFF, 16'd7, 16'h0000, 16'h0000, 16'h0001, 16'h1234};
        int dc;
        logic [31:0] r;
        logic e, sok, stok;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], dc, r, e, sok, stok);
            checks++;
            if (r !== ref_result(ops[i], as[i], bs[i])) begin
                errors++;
                $display("[TB] FAIL dir%0d_result got %h exp %h", i, r, ref_result(ops[i], as[i], bs[i]));
            end
            checks++;
            if (e !== ref_err(ops[i], bs[i])) begin
                errors++;
                $display("[TB] FAIL dir%0d_err got %b exp %b", i, e, ref_err(ops[i], bs[i]));
            end
            checks++;
            if (dc !== ref_lat(ops[i], bs[i])) begin
                errors++;
                $display("[TB] FAIL dir%0d_latency got %0d exp %0d", i, dc, ref_lat(ops[i], bs[i]));
            end
            checks++;
            if ({sok, stok} !== 2'b11) begin
                errors++;
                $display("[TB] FAIL dir%0d_status got %b exp 11", i, {sok, stok});
            end
        end
    endtask

    task automatic test_random();
        int dc;
        logic [31:0] r;
        logic e, sok, stok;
        logic [1:0] op;
        logic [15:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(3, 0));
            case ($urandom_range(3, 0))
                0: a = 16'h0000;
                1: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(4, 0))
                0: b = 16'h0000;
                1: b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            do_op(op, a, b, dc, r, e, sok, stok);
            checks++;
            if (r !== ref_result(op, a, b) || e !== ref_err(op, b)) begin
                errors++;
                $display("[TB] FAIL rnd%0d op%0d a=%h b=%h got %h/%b exp %h/%b", i, op, a, b, r, e,
                         ref_result(op, a, b), ref_err(op, b));
            end
            checks++;
            if (dc !== ref_lat(op, b) || {sok, stok} !== 2'b11) begin
                errors++;
                $display("[TB] FAIL rnd%0d_timing got lat %0d status %b exp lat %0d status 11", i, dc,
                         {sok, stok}, ref_lat(op, b));
            end
        end
    endtask

    task automatic test_ignore_inputs();
        int pulses, done_at, late_busy;
        logic [31:0] r;
        pulses = 0;
        done_at = -1;
        late_busy = 0;
        r = '0;
        enable_i = 1'b0;
        tick();
        opcode_i = T_MUL;
        operate_a_i = 16'd3;
        operate_b_i = 16'd5;
        enable_i = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            if (c == 4) begin
                enable_i = 1'b0;
                opcode_i = T_ADD;
                operate_a_i = 16'hFFFF;
                operate_b_i = 16'hFFFF;
            end
            if (c == 5) enable_i = 1'b1;
            tick();
            if (done_at >= 0 && busy_o === 1'b1) late_busy++;
            if (done_o === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = c;
                    r = result_o;
                end
            end
        end
        checks++;
        if (pulses !== 1 || done_at !== 16) begin
            errors++;
            $display("[TB] FAIL ignore_pulses got %0d at %0d exp 1 at 16", pulses, done_at);
        end
        checks++;
        if (r !== ref_result(T_MUL, 16'd3, 16'd5)) begin
            errors++;
            $display("[TB] FAIL ignore_result got %h exp %h", r, ref_result(T_MUL, 16'd3, 16'd5));
        end
        checks++;
        if (late_busy !== 0) begin
            errors++;
            $display("[TB] FAIL ignore_extra_op got %0d busy cycles exp 0", late_busy);
        end
        enable_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int dc;
        logic [31:0] r;
        logic e, sok, stok;
        enable_i = 1'b0;
        tick();
        opcode_i = T_DIV;
        operate_a_i = 16'd1000;
        operate_b_i = 16'd3;
        enable_i = 1'b1;
        tick();
        repeat (8) tick();
        hresetn_i = 1'b0;
        #1;
        checks++;
        if ({result_o, busy_o, done_o, err_o} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid got %h exp 0", {result_o, busy_o, done_o, err_o});
        end
        enable_i = 1'b0;
        repeat (2) tick();
        hresetn_i = 1'b1;
        tick();
        do_op(T_ADD, 16'd2, 16'd3, dc, r, e, sok, stok);
        checks++;
        if (r !== ref_result(T_ADD, 16'd2, 16'd3) || dc !== 1 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_add got %h lat %0d err %b exp %h lat 1 err 0", r, dc, e,
                     ref_result(T_ADD, 16'd2, 16'd3));
        end
    endtask

    task automatic test_hold_enable();
        int pulses, busy_cyc;
        logic [31:0] r;
        pulses = 0;
        busy_cyc = 0;
        r = '0;
        enable_i = 1'b0;
        tick();
        opcode_i = T_ADD;
        operate_a_i = 16'd7;
        operate_b_i = 16'd8;
        enable_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (busy_o === 1'b1) busy_cyc++;
            if (done_o === 1'b1) begin
                pulses++;
                r = result_o;
            end
        end
        checks++;
        if (pulses !== 1 || busy_cyc !== 1) begin
            errors++;
            $display("[TB] FAIL hold_single got %0d pulses %0d busy exp 1 and 1", pulses, busy_cyc);
        end
        checks++;
        if (r !== ref_result(T_ADD, 16'd7, 16'd8)) begin
            errors++;
            $display("[TB] FAIL hold_result got %h exp %h", r, ref_result(T_ADD, 16'd7, 16'd8));
        end
        enable_i = 1'b0;
        tick();
        opcode_i = T_SUB;
        operate_a_i = 16'd9;
        operate_b_i = 16'd4;
        enable_i = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done_o === 1'b1) begin
                pulses++;
                r = result_o;
            end
        end
        checks++;
        if (pulses !== 1 || r !== ref_result(T_SUB, 16'd9, 16'd4)) begin
            errors++;
            $display("[TB] FAIL hold_restart got %0d pulses result %h exp 1 and %h", pulses, r,
                     ref_result(T_SUB, 16'd9, 16'd4));
        end
        enable_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_inputs();
        test_reset_mid();
        test_hold_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
